// File: rtl/norm_shift_seq.sv
// norm_shift_seq: iterative normalizer for two's-complement fractional operands.
// The operand shifts left one bit per clock until its two top bits differ.
// The design then reports the normalized mantissa and the number of shifts.
// shift_cnt feeds a power-of-2 decoder directly, so it never exceeds MAX_SHIFT.
`timescale 1ns/1ps
module norm_shift_seq #(
  parameter int DATA_W    = 24,
  parameter int CNT_W     = 5,
  parameter int MAX_SHIFT = 23
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] norm_out,
  output logic [CNT_W-1:0]  shift_cnt,
  output logic              zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic signed [DATA_W-1:0] mant_q, mant_d;
  logic        [CNT_W-1:0]  cnt_q, cnt_d;
  logic                     zero_q, zero_d;

  // Top two bits differ: the operand is normalized.
  // For a zero operand this never occurs, so zero skips SHIFT entirely.
  logic normalized;
  logic at_max;

  assign normalized = (mant_q[DATA_W-1] != mant_q[DATA_W-2]);
  assign at_max     = (cnt_q == CNT_W'(MAX_SHIFT));

  // State and working registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mant_q  <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mant_q  <= mant_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
    end
  end

  // Next-state logic. The operand is captured from either IDLE or DONE.
  // Capturing from DONE lets operations run back-to-back.
  always_comb begin
    state_d = state_q;
    mant_d  = mant_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mant_d = din;
          cnt_d  = '0;
          if (din == '0) begin
            zero_d  = 1'b1;
            state_d = DONE;
          end else begin
            zero_d  = 1'b0;
            state_d = SHIFT;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (normalized || at_max) begin
          state_d = DONE;
        end else begin
          // Zeros enter at the LSB. The sign survives because shifting stops
          // before the sign bit would be overwritten.
          mant_d = {mant_q[DATA_W-2:0], 1'b0};
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The working registers also hold the result, so it stays valid in IDLE.
  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == DONE);
  assign norm_out  = mant_q;
  assign shift_cnt = cnt_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_norm_shift_seq.sv
// Directed bench for norm_shift_seq with a queue scoreboard of expected results.
`timescale 1ns/1ps
module tb_norm_shift_seq;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [23:0] din;
  logic        busy;
  logic        done;
  logic [23:0] norm_out;
  logic [4:0]  shift_cnt;
  logic        zero;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [23:0] norm;
    logic [4:0]  cnt;
    logic        z;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t last_e;

  norm_shift_seq #(.DATA_W(24), .CNT_W(5), .MAX_SHIFT(23)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .din      (din),
    .busy     (busy),
    .done     (done),
    .norm_out (norm_out),
    .shift_cnt(shift_cnt),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: locate the highest bit that differs from the sign bit.
  function automatic exp_t model(input logic [23:0] d);
    exp_t e;
    int   sh;
    bit   found;
    sh    = 23;
    found = 1'b0;
    for (int i = 22; i >= 0; i--) begin
      if (!found && d[i] != d[23]) begin
        sh    = 22 - i;
        found = 1'b1;
      end
    end
    if (d == 24'h0) begin
      e.norm = 24'h0; e.cnt = 5'd0; e.z = 1'b1; e.lat = 1;
    end else begin
      e.norm = d << sh; e.cnt = 5'(sh); e.z = 1'b0; e.lat = sh + 2;
    end
    return e;
  endfunction

  task automatic start_op(input logic [23:0] d);
    @(negedge clk);
    start = 1'b1;
    din   = d;
    sb.push_back(model(d));
  endtask

  // Waits for done, counting cycles from the capture edge.
  // Optionally pulses start at cycle inj_cyc while the operation is running.
  task automatic wait_done(input int inj_cyc, input logic [23:0] inj_din);
    int   lat;
    exp_t e;
    lat = 1;
    @(posedge clk); #1;
    start = 1'b0;
    while (done !== 1'b1 && lat < 60) begin
      chk("busy_while_run", busy, 1);
      if (lat == inj_cyc) begin
        start = 1'b1;
        din   = inj_din;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("done_seen", done, 1);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'(sb.size()), 1);
    end else begin
      e = sb.pop_front();
      last_e = e;
      chk("norm_out", norm_out, e.norm);
      chk("shift_cnt", shift_cnt, e.cnt);
      chk("zero", zero, e.z);
      chk("latency", lat, e.lat);
      chk("busy_at_done", busy, 0);
    end
  endtask

  // After done with start low: one-cycle pulse, outputs held in IDLE.
  task automatic chk_hold();
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("busy_idle", busy, 0);
    chk("hold_norm", norm_out, last_e.norm);
    chk("hold_cnt", shift_cnt, last_e.cnt);
    chk("hold_zero", zero, last_e.z);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    din     = 24'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_norm", norm_out, 0);
    chk("rst_cnt", shift_cnt, 0);
    chk("rst_zero", zero, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Already normalized positive operand.
    start_op(24'h400000); wait_done(0, 24'h0); chk_hold();
    repeat (2) @(posedge clk);

    // Smallest positive operand: 22 shifts.
    start_op(24'h000001); wait_done(0, 24'h0); chk_hold();
    repeat (2) @(posedge clk);

    // All ones runs to MAX_SHIFT, then back-to-back start from DONE.
    start_op(24'hFFFFFF); wait_done(0, 24'h0);
    start_op(24'hC00000); wait_done(0, 24'h0); chk_hold();

    // Zero operand goes straight to DONE.
    start_op(24'h000000); wait_done(0, 24'h0); chk_hold();

    // start while busy is ignored.
    start_op(24'h000100); wait_done(3, 24'h400000); chk_hold();

    // Negative operand and an already normalized negative operand.
    start_op(24'hF00000); wait_done(0, 24'h0);
    start_op(24'h9ABCDE); wait_done(0, 24'h0); chk_hold();

    // Reset during the 10th SHIFT cycle discards the operation.
    @(negedge clk);
    start = 1'b1;
    din   = 24'h000001;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("midshift_busy", busy, 1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_norm", norm_out, 0);
    chk("mrst_cnt", shift_cnt, 0);
    chk("mrst_zero", zero, 0);
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      chk("no_done_after_rst", done, 0);
    end

    // Normal operation resumes.
    start_op(24'h123456); wait_done(0, 24'h0); chk_hold();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
